// File: rtl/dm_arbiter.sv
// Two-port (CPU C / debug-DMA D) data-memory arbiter with a registered command and a one-cycle ack.
// Optional misalignment trapping: define DM_ARB_ALIGN_CHECK_EN.
module dm_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 4
)(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              C_Req,
  input  logic              C_WE,
  input  logic [1:0]        C_MemDst,
  input  logic [31:0]       C_Addr,
  input  logic [31:0]       C_WD,
  input  logic [31:0]       C_Pc,
  output logic              C_Ack,
  output logic [31:0]       C_RD,
  output logic              C_Err,
  output logic              C_Stall,
  input  logic              D_Req,
  input  logic              D_WE,
  input  logic [1:0]        D_MemDst,
  input  logic [31:0]       D_Addr,
  input  logic [31:0]       D_WD,
  output logic              D_Ack,
  output logic [31:0]       D_RD,
  output logic              D_Err,
  output logic              DM_WE,
  output logic [1:0]        DM_MemDst,
  output logic [ADDR_W-1:0] DM_A,
  output logic [31:0]       DM_WD,
  output logic [31:0]       DM_Pc,
  output logic [31:0]       DM_Addr,
  input  logic [31:0]       DM_RD
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [1:0]  dst;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        err;
  } cmd_t;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t     state;
  cmd_t       cmd, nxt;
  logic [2:0] wait_cnt;
  logic       issue, c_elig, d_elig, d_pri, pick_d, latch, own_c, own_d;

  assign issue  = (state == ISSUE);
  // The current owner's request is its own held request; it is not re-arbitrated in its ack cycle.
  assign c_elig = C_Req & ~(issue & (cmd.owner == OWN_C));
  assign d_elig = D_Req & ~(issue & (cmd.owner == OWN_D));
  assign d_pri  = (int'(wait_cnt) >= MAX_WAIT);
  assign pick_d = d_elig & (~c_elig | d_pri);
  assign latch  = c_elig | d_elig;

  always_comb begin
    nxt       = '0;
    nxt.owner = pick_d;
    if (pick_d) begin
      nxt.we   = D_WE;
      nxt.dst  = D_MemDst;
      nxt.addr = D_Addr;
      nxt.wd   = D_WD;
    end else begin
      nxt.we   = C_WE;
      nxt.dst  = C_MemDst;
      nxt.addr = C_Addr;
      nxt.wd   = C_WD;
      nxt.pc   = C_Pc;
    end
`ifdef DM_ARB_ALIGN_CHECK_EN
    nxt.err = ((nxt.dst == 2'b00) && (nxt.addr[1:0] != 2'b00)) ||
              ((nxt.dst == 2'b01) && nxt.addr[0]) ||
              (nxt.dst == 2'b11);
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cmd      <= '0;
      wait_cnt <= '0;
    end else begin
      if (latch) begin
        cmd   <= nxt;
        state <= ISSUE;
      end else begin
        state <= IDLE;
      end
      if (d_elig && !(latch && pick_d))
        wait_cnt <= (wait_cnt == 3'd7) ? wait_cnt : wait_cnt + 3'd1;
      else
        wait_cnt <= '0;
    end
  end

  assign own_c = issue & (cmd.owner == OWN_C);
  assign own_d = issue & (cmd.owner == OWN_D);

  // Memory drive is gated by state so an async reset mid-ISSUE kills the write at once.
  assign DM_WE     = issue & cmd.we & ~cmd.err;
  assign DM_MemDst = issue ? cmd.dst : 2'b00;
  assign DM_A      = issue ? cmd.addr[ADDR_W-1:0] : '0;
  assign DM_WD     = issue ? cmd.wd : '0;
  assign DM_Addr   = issue ? cmd.addr : '0;
  assign DM_Pc     = own_c ? cmd.pc : '0;

  assign C_Ack   = own_c;
  assign D_Ack   = own_d;
  assign C_RD    = (own_c & ~cmd.err) ? DM_RD : '0;
  assign D_RD    = (own_d & ~cmd.err) ? DM_RD : '0;
  assign C_Stall = Reset_n & C_Req & ~C_Ack;

`ifdef DM_ARB_ALIGN_CHECK_EN
  assign C_Err = own_c & cmd.err;
  assign D_Err = own_d & cmd.err;
`else
  assign C_Err = 1'b0;
  assign D_Err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter: byte memory behind DM_*, and an order-based reference memory.
module tb_dm_arbiter;
  localparam int AW  = 12;
  localparam int MW  = 4;
  localparam int MSK = (1 << AW) - 1;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          C_Req, C_WE, D_Req, D_WE;
  logic [1:0]    C_MemDst, D_MemDst;
  logic [31:0]   C_Addr, C_WD, C_Pc, D_Addr, D_WD;
  logic          C_Ack, C_Err, C_Stall, D_Ack, D_Err;
  logic [31:0]   C_RD, D_RD;
  logic          DM_WE;
  logic [1:0]    DM_MemDst;
  logic [AW-1:0] DM_A;
  logic [31:0]   DM_WD, DM_Pc, DM_Addr, DM_RD;

  dm_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .C_Req(C_Req), .C_WE(C_WE), .C_MemDst(C_MemDst), .C_Addr(C_Addr), .C_WD(C_WD), .C_Pc(C_Pc),
    .C_Ack(C_Ack), .C_RD(C_RD), .C_Err(C_Err), .C_Stall(C_Stall),
    .D_Req(D_Req), .D_WE(D_WE), .D_MemDst(D_MemDst), .D_Addr(D_Addr), .D_WD(D_WD),
    .D_Ack(D_Ack), .D_RD(D_RD), .D_Err(D_Err),
    .DM_WE(DM_WE), .DM_MemDst(DM_MemDst), .DM_A(DM_A), .DM_WD(DM_WD),
    .DM_Pc(DM_Pc), .DM_Addr(DM_Addr), .DM_RD(DM_RD));

  always #5 Clk = ~Clk;

  // Memory seen by the DUT: little-endian, sign-extending half/byte reads, 11 treated as byte.
  logic [7:0] mem  [0:MSK];
  logic [7:0] refm [0:MSK];

  initial for (int i = 0; i <= MSK; i++) mem[i] <= 8'h00;

  always_comb begin
    int a;
    a = int'(DM_A);
    case (DM_MemDst)
      2'b00:   DM_RD = {mem[(a+3)&MSK], mem[(a+2)&MSK], mem[(a+1)&MSK], mem[a]};
      2'b01:   DM_RD = {{16{mem[(a+1)&MSK][7]}}, mem[(a+1)&MSK], mem[a]};
      default: DM_RD = {{24{mem[a][7]}}, mem[a]};
    endcase
  end

  always @(posedge Clk) begin
    if (DM_WE) begin
      mem[int'(DM_A)] <= DM_WD[7:0];
      if (DM_MemDst == 2'b00 || DM_MemDst == 2'b01) mem[(int'(DM_A)+1)&MSK] <= DM_WD[15:8];
      if (DM_MemDst == 2'b00) begin
        mem[(int'(DM_A)+2)&MSK] <= DM_WD[23:16];
        mem[(int'(DM_A)+3)&MSK] <= DM_WD[31:24];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference: value a completed access returns, whether it traps, and its effect on memory.
  function automatic logic ref_err(input logic [1:0] dst, input logic [31:0] a);
`ifdef DM_ARB_ALIGN_CHECK_EN
    return (dst == 2'b00 && a[1:0] != 2'b00) || (dst == 2'b01 && a[0]) || dst == 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_rd(input logic [1:0] dst, input logic [31:0] a);
    int b;
    logic [31:0] w;
    b = int'(a) & MSK;
    w = {refm[(b+3)&MSK], refm[(b+2)&MSK], refm[(b+1)&MSK], refm[b]};
    if (dst == 2'b00) return w;
    if (dst == 2'b01) return {{16{w[15]}}, w[15:0]};
    return {{24{w[7]}}, w[7:0]};
  endfunction

  task automatic ref_wr(input logic [1:0] dst, input logic [31:0] a, input logic [31:0] wd);
    int b, n;
    b = int'(a) & MSK;
    n = (dst == 2'b00) ? 4 : (dst == 2'b01) ? 2 : 1;
    for (int k = 0; k < n; k++) refm[(b+k)&MSK] = wd[8*k +: 8];
  endtask

  // Observations captured by xfer (cycle index 0 = request cycle).
  int          c_at, d_at;
  logic [31:0] c_rd, d_rd, c_pc, d_pc;
  logic        c_err, d_err, c_we, d_we, overlap, leak;
  logic [7:0]  stall;

  task automatic xfer(input logic cr, input logic cwe, input logic [1:0] cdst, input logic [31:0] ca,
                      input logic [31:0] cwd, input logic [31:0] cpc,
                      input logic dr, input logic dwe, input logic [1:0] ddst, input logic [31:0] da,
                      input logic [31:0] dwd);
    c_at = -1; d_at = -1; overlap = 0; leak = 0; stall = '0;
    c_rd = '0; d_rd = '0; c_pc = '0; d_pc = '0; c_err = 0; d_err = 0; c_we = 0; d_we = 0;
    @(posedge Clk); #1;
    C_WE = cwe; C_MemDst = cdst; C_Addr = ca; C_WD = cwd; C_Pc = cpc; C_Req = cr;
    D_WE = dwe; D_MemDst = ddst; D_Addr = da; D_WD = dwd; D_Req = dr;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      stall[k] = C_Stall;
      if (C_Ack && D_Ack) overlap = 1;
      if (C_Ack) begin
        c_at = k; c_rd = C_RD; c_err = C_Err; c_we = DM_WE; c_pc = DM_Pc;
        if (D_RD !== 32'd0 || D_Err !== 1'b0) leak = 1;
      end
      if (D_Ack) begin
        d_at = k; d_rd = D_RD; d_err = D_Err; d_we = DM_WE; d_pc = DM_Pc;
        if (C_RD !== 32'd0 || C_Err !== 1'b0) leak = 1;
      end
      @(posedge Clk); #1;
      if (c_at >= 0) C_Req = 0;
      if (d_at >= 0) D_Req = 0;
      if ((!cr || c_at >= 0) && (!dr || d_at >= 0)) break;
    end
    C_Req = 0; D_Req = 0;
  endtask

  task automatic test_reset();
    Reset_n = 0; C_Req = 1; D_Req = 1; C_WE = 1; D_WE = 1; C_MemDst = 2'b00; D_MemDst = 2'b00;
    C_Addr = 32'h10; D_Addr = 32'h20; C_WD = 32'h1; D_WD = 32'h2; C_Pc = 32'h100;
    for (int i = 0; i <= MSK; i++) refm[i] = 8'h00;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (C_Ack !== 1'b0)    begin errors++; $display("FAIL rst_c_ack got=%b exp=0", C_Ack); end
    checks++; if (D_Ack !== 1'b0)    begin errors++; $display("FAIL rst_d_ack got=%b exp=0", D_Ack); end
    checks++; if (DM_WE !== 1'b0)    begin errors++; $display("FAIL rst_dm_we got=%b exp=0", DM_WE); end
    checks++; if (C_Stall !== 1'b0)  begin errors++; $display("FAIL rst_stall got=%b exp=0", C_Stall); end
    checks++; if (DM_Addr !== 32'd0) begin errors++; $display("FAIL rst_dm_addr got=%h exp=0", DM_Addr); end
    checks++; if (DM_Pc !== 32'd0)   begin errors++; $display("FAIL rst_dm_pc got=%h exp=0", DM_Pc); end
    checks++; if (C_RD !== 32'd0)    begin errors++; $display("FAIL rst_c_rd got=%h exp=0", C_RD); end
    C_Req = 0; D_Req = 0;
    @(posedge Clk); #1 Reset_n = 1;
  endtask

  task automatic test_c_write_read();
    xfer(1, 1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0000_0400, 0, 0, 2'b00, 0, 0);
    ref_wr(2'b00, 32'h10, 32'hDEADBEEF);
    checks++; if (c_at !== 1)               begin errors++; $display("FAIL cw_ack_cycle got=%0d exp=1", c_at); end
    checks++; if (c_we !== 1'b1)            begin errors++; $display("FAIL cw_dm_we got=%b exp=1", c_we); end
    checks++; if (c_pc !== 32'h400)         begin errors++; $display("FAIL cw_dm_pc got=%h exp=400", c_pc); end
    checks++; if (stall !== 8'b0000_0001)   begin errors++; $display("FAIL cw_stall got=%b exp=00000001", stall); end
    xfer(1, 0, 2'b00, 32'h10, 0, 32'h0000_0404, 0, 0, 2'b00, 0, 0);
    checks++; if (c_at !== 1)               begin errors++; $display("FAIL cr_ack_cycle got=%0d exp=1", c_at); end
    checks++; if (c_rd !== 32'hDEADBEEF)    begin errors++; $display("FAIL cr_rd got=%h exp=deadbeef", c_rd); end
  endtask

  task automatic test_simultaneous();
    xfer(1, 0, 2'b00, 32'h10, 0, 32'h500, 1, 0, 2'b01, 32'h12, 0);
    checks++; if (c_at !== 1)             begin errors++; $display("FAIL sim_c_cycle got=%0d exp=1", c_at); end
    checks++; if (d_at !== 2)             begin errors++; $display("FAIL sim_d_cycle got=%0d exp=2", d_at); end
    checks++; if (overlap !== 1'b0)       begin errors++; $display("FAIL sim_overlap got=%b exp=0", overlap); end
    checks++; if (stall !== 8'b0000_0001) begin errors++; $display("FAIL sim_stall got=%b exp=00000001", stall); end
    checks++; if (d_rd !== 32'hFFFFDEAD)  begin errors++; $display("FAIL sim_d_rd got=%h exp=ffffdead", d_rd); end
    checks++; if (d_pc !== 32'd0)         begin errors++; $display("FAIL sim_d_pc got=%h exp=0", d_pc); end
  endtask

  task automatic test_starve();
    int doff, dack, cacks;
    logic ov;
    doff = $urandom_range(0, 3); dack = -1; cacks = 0; ov = 0;
    @(posedge Clk); #1;
    C_WE = 0; C_MemDst = 2'b00; C_Addr = 32'h10; D_WE = 0; D_MemDst = 2'b00; D_Addr = 32'h10;
    C_Req = 1;
    for (int k = 0; k < 16; k++) begin
      if (k == doff) D_Req = 1;
      @(negedge Clk);
      if (C_Ack && D_Ack) ov = 1;
      if (C_Ack) cacks++;
      if (D_Ack && dack < 0) dack = k - doff;
      @(posedge Clk); #1;
      if (dack >= 0) D_Req = 0;
    end
    C_Req = 0; D_Req = 0;
    repeat (2) @(posedge Clk); #1;
    checks++; if (!(dack >= 1 && dack <= 6)) begin errors++; $display("FAIL starve_d_latency got=%0d exp=1..6", dack); end
    checks++; if (ov !== 1'b0)               begin errors++; $display("FAIL starve_overlap got=%b exp=0", ov); end
    checks++; if (cacks < 4)                 begin errors++; $display("FAIL starve_c_acks got=%0d exp>=4", cacks); end
  endtask

  task automatic test_align();
    logic e;
    logic [31:0] exp_w;
    e = ref_err(2'b01, 32'h13);
    xfer(1, 1, 2'b01, 32'h13, 32'h0000_1234, 32'h600, 0, 0, 2'b00, 0, 0);
    if (!e) ref_wr(2'b01, 32'h13, 32'h1234);
`ifdef DM_ARB_ALIGN_CHECK_EN
    exp_w = 32'hDEADBEEF;
`else
    exp_w = 32'h34ADBEEF;
`endif
    checks++; if (c_at !== 1)  begin errors++; $display("FAIL al_ack got=%0d exp=1", c_at); end
    checks++; if (c_err !== e) begin errors++; $display("FAIL al_err got=%b exp=%b", c_err, e); end
    checks++; if (c_we !== !e) begin errors++; $display("FAIL al_dm_we got=%b exp=%b", c_we, !e); end
    xfer(1, 0, 2'b00, 32'h10, 0, 32'h604, 0, 0, 2'b00, 0, 0);
    checks++; if (c_rd !== exp_w) begin errors++; $display("FAIL al_mem got=%h exp=%h", c_rd, exp_w); end
  endtask

  task automatic test_reset_mid();
    @(posedge Clk); #1;
    D_WE = 1; D_MemDst = 2'b10; D_Addr = 32'h30; D_WD = 32'h55; D_Req = 1;
    @(posedge Clk); #1;
    checks++; if (D_Ack !== 1'b1) begin errors++; $display("FAIL rm_pre_ack got=%b exp=1", D_Ack); end
    checks++; if (DM_WE !== 1'b1) begin errors++; $display("FAIL rm_pre_we got=%b exp=1", DM_WE); end
    #1 Reset_n = 0;
    #1;
    checks++; if (DM_WE !== 1'b0) begin errors++; $display("FAIL rm_we_drop got=%b exp=0", DM_WE); end
    checks++; if (D_Ack !== 1'b0) begin errors++; $display("FAIL rm_ack_drop got=%b exp=0", D_Ack); end
    D_Req = 0;
    @(posedge Clk); #1 Reset_n = 1;
    @(negedge Clk);
    checks++; if (D_Ack !== 1'b0 || C_Ack !== 1'b0 || DM_WE !== 1'b0)
      begin errors++; $display("FAIL rm_idle got=%b%b%b exp=000", D_Ack, C_Ack, DM_WE); end
    xfer(0, 0, 2'b00, 0, 0, 0, 1, 0, 2'b10, 32'h30, 0);
    checks++; if (d_at !== 1)       begin errors++; $display("FAIL rm_read_ack got=%0d exp=1", d_at); end
    checks++; if (d_rd !== 32'd0)   begin errors++; $display("FAIL rm_mem got=%h exp=0", d_rd); end
  endtask

  task automatic test_d_byte();
    xfer(0, 0, 2'b00, 0, 0, 0, 1, 1, 2'b10, 32'h21, 32'h0000_0080);
    ref_wr(2'b10, 32'h21, 32'h80);
    checks++; if (d_we !== 1'b1) begin errors++; $display("FAIL db_we got=%b exp=1", d_we); end
    xfer(0, 0, 2'b00, 0, 0, 0, 1, 0, 2'b10, 32'h21, 0);
    checks++; if (d_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL db_rd got=%h exp=ffffff80", d_rd); end
    checks++; if (leak !== 1'b0)         begin errors++; $display("FAIL db_c_rd_leak got=%b exp=0", leak); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int mode, ec, ed;
      logic cwe, dwe, ce, de;
      logic [1:0] cdst, ddst;
      logic [31:0] ca, da, cwd, dwd, cpc, crd_e, drd_e;
      mode = $urandom_range(0, 2);
      cwe = 1'($urandom); dwe = 1'($urandom); cdst = 2'($urandom); ddst = 2'($urandom);
      ca = $urandom_range(0, 255); da = $urandom_range(0, 255);
      cwd = $urandom; dwd = $urandom; cpc = $urandom;
      ce = ref_err(cdst, ca); de = ref_err(ddst, da);
      crd_e = '0; drd_e = '0; ec = -1; ed = -1;
      if (mode != 1) begin
        ec = 1; crd_e = ce ? 32'd0 : ref_rd(cdst, ca);
        if (cwe && !ce) ref_wr(cdst, ca, cwd);
      end
      if (mode != 0) begin
        ed = (mode == 2) ? 2 : 1; drd_e = de ? 32'd0 : ref_rd(ddst, da);
        if (dwe && !de) ref_wr(ddst, da, dwd);
      end
      xfer(mode != 1, cwe, cdst, ca, cwd, cpc, mode != 0, dwe, ddst, da, dwd);
      checks++; if (c_at !== ec)     begin errors++; $display("FAIL rnd%0d_c_cycle got=%0d exp=%0d", it, c_at, ec); end
      checks++; if (d_at !== ed)     begin errors++; $display("FAIL rnd%0d_d_cycle got=%0d exp=%0d", it, d_at, ed); end
      checks++; if (c_rd !== crd_e)  begin errors++; $display("FAIL rnd%0d_c_rd got=%h exp=%h", it, c_rd, crd_e); end
      checks++; if (d_rd !== drd_e)  begin errors++; $display("FAIL rnd%0d_d_rd got=%h exp=%h", it, d_rd, drd_e); end
      checks++; if (c_err !== (mode != 1 && ce)) begin errors++; $display("FAIL rnd%0d_c_err got=%b", it, c_err); end
      checks++; if (d_err !== (mode != 0 && de)) begin errors++; $display("FAIL rnd%0d_d_err got=%b", it, d_err); end
      checks++; if (c_pc !== ((mode != 1) ? cpc : 32'd0)) begin errors++; $display("FAIL rnd%0d_c_pc got=%h", it, c_pc); end
      checks++; if (overlap !== 1'b0 || leak !== 1'b0)
        begin errors++; $display("FAIL rnd%0d_exclusive got=%b%b exp=00", it, overlap, leak); end
    end
  endtask

  initial begin
    test_reset();
    test_c_write_read();
    test_simultaneous();
    test_starve();
    test_align();
    test_reset_mid();
    test_d_byte();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
